brush_writer: RTL
=================

# brush_writer

Write-side engine for the 128x128, 3-bit-color pixel store. It turns brush strokes (`brush`, `newColor`, `wx`, `wy`) and a clear request into a serialized stream of single-pixel writes, one per clock, on the pixel RAM write port. The VGA read path consumes the same RAM on the other port. The block sits between the input/decode logic and the pixel RAM.

## Interface
- `RADIUS`, 1: brush half-width; each stamp is a (2*RADIUS+1)² square centered on (`wx`,`wy`).
- `CBITS`, 7: canvas coordinate bits; canvas is 2^CBITS square.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `brush`  in  1  level paint request; sampled only when `ready`=1.
- `clear`  in  1  level clear-canvas request; sampled only when `ready`=1.
- `newColor`  in  3  stamp color code.
- `wx`, `wy`  in  8  brush center; values ≥128 are legal and are clipped.
- `ready`  out  1  high only in IDLE.
- `wr_en`  out  1  pixel write strobe.
- `wr_addr`  out  2*CBITS  {y[6:0], x[6:0]}.
- `wr_data`  out  3  color code to write.

## Operation
- States: IDLE, STAMP, CLEAR.
- IDLE: `ready`=1, `wr_en`=0.
  - `clear`=1 → CLEAR. Clear wins over a simultaneous `brush`.
  - Otherwise, `brush`=1 and not a duplicate → latch `wx`,`wy`,`newColor`, set offsets dx=dy=-RADIUS, go to STAMP.
  - Duplicate: a stamp has completed since reset or the last clear, and the current (`wx`,`wy`,`newColor`) equals that stamp's latched values. A duplicate stays in IDLE with no write.
- STAMP:
  - Scan dx fastest, dx,dy from -RADIUS..+RADIUS. Compute px=cx+dx and py=cy+dy as signed 10-bit values.
  - `wr_en`=1 only if 0≤px<128 and 0≤py<128. Clipped pixels still take their cycle.
  - `wr_data` = latched color.
  - After (RADIUS,RADIUS): record the latched triple as last-stamp and set last-valid. Go to IDLE.
- CLEAR:
  - Address counter runs 0..16383 with `wr_en`=1 and `wr_data`=ERASE every cycle.
  - After address 16383: clear last-valid and go to IDLE.
- Inputs are ignored outside IDLE. New requests are not queued.
- A `brush` held high with moving coordinates produces back-to-back stamps separated by one IDLE cycle.

## Timing
- Reset (async assert, `reset`=0):
  - state=IDLE, `ready`=1, `wr_en`=0, `wr_addr`=0, `wr_data`=0, last-valid=0.
  - Reset mid-STAMP or mid-CLEAR aborts immediately. No further writes occur.
- Acceptance happens at the rising edge where `ready`=1 and a request is high. The first write cycle is the next cycle. `ready`=0 from that cycle on.
- `wr_en`, `wr_addr` and `wr_data` are driven from registers only. There is no combinational path from any input.
- STAMP lasts exactly (2*RADIUS+1)² cycles, 9 at the default. `ready` returns the cycle after the last stamp cycle.
- CLEAR lasts exactly 16384 cycles.
- Clip math: cx=0, RADIUS=1 yields px=-1, which is clipped, never wrapped to 127.

## Structure
- Shared package (alongside `colors.svh`/`vgaParameters.svh`) holds:
  - the color code constants, including ERASE;
  - canvas size constants `CANVAS_BITS`=7 and `CANVAS_SIZE`=128;
  - the state enum `brush_state_t`.
- One natural sub-module, `stamp_scanner`: the dx/dy offset counter plus the signed add-and-clip producing px, py and `in_range`. The FSM, dedupe register and clear counter stay in `brush_writer`.

## Test plan
- Reset, then `brush`=1, `wx`=10, `wy`=20, `newColor`=red for one cycle → 9 writes at x 9..11, y 19..21, rows in order; `ready` low for 9 cycles, then high.
- `wx`=0, `wy`=0 stamp → 9 cycles elapse, only 4 writes (addresses {0,0},{0,1},{1,0},{1,1}); no writes to x or y=127.
- `wx`=200, `wy`=50 → 9 cycles, zero writes, `ready` returns.
- Hold `brush` at (40,40,green) for 50 cycles → exactly one 9-write stamp. Then move to (41,40) → a second stamp starts after one IDLE cycle.
- `clear` and `brush` high together in IDLE → CLEAR wins: 16384 consecutive ERASE writes at addresses 0..16383. A following identical stamp is then not deduped.
- Assert `reset` at CLEAR address 5000 → `wr_en` drops asynchronously, `ready`=1, and a new stamp after release works normally.

Source files
------------

// File: rtl/brush_writer_pkg.sv
// Shared definitions for the pixel-store write engine: color codes,
// canvas geometry and the writer state encoding.
package brush_writer_pkg;

  localparam int COLOR_BITS  = 3;
  localparam int CANVAS_BITS = 7;
  localparam int CANVAS_SIZE = 128;

  localparam logic [COLOR_BITS-1:0] BLACK   = 3'd0;
  localparam logic [COLOR_BITS-1:0] RED     = 3'd1;
  localparam logic [COLOR_BITS-1:0] GREEN   = 3'd2;
  localparam logic [COLOR_BITS-1:0] YELLOW  = 3'd3;
  localparam logic [COLOR_BITS-1:0] BLUE    = 3'd4;
  localparam logic [COLOR_BITS-1:0] MAGENTA = 3'd5;
  localparam logic [COLOR_BITS-1:0] CYAN    = 3'd6;
  localparam logic [COLOR_BITS-1:0] WHITE   = 3'd7;
  // The canvas background; a cleared pixel reads back as this code.
  localparam logic [COLOR_BITS-1:0] ERASE   = BLACK;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STAMP = 2'd1,
    ST_CLEAR = 2'd2
  } brush_state_t;

endpackage

// File: rtl/stamp_scanner.sv
// Brush offset counter plus signed add-and-clip. Outputs describe the pixel
// that will be presented next, so the caller can register them directly.
module stamp_scanner #(
  parameter int RADIUS = 1,
  parameter int CBITS  = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               step,
  input  logic [7:0]         cx,
  input  logic [7:0]         cy,
  output logic [2*CBITS-1:0] addr,
  output logic               in_range,
  output logic               last
);

  localparam logic signed [9:0] R     = 10'(RADIUS);
  localparam logic signed [9:0] LIMIT = 10'(2 ** CBITS);

  logic signed [9:0] dx_reg, dy_reg;
  logic signed [9:0] dx_next, dy_next;
  logic signed [9:0] px, py;

  always_comb begin
    dx_next = dx_reg;
    dy_next = dy_reg;
    if (start) begin
      dx_next = -R;
      dy_next = -R;
    end else if (step) begin
      if (dx_reg == R) begin
        dx_next = -R;
        dy_next = dy_reg + 10'sd1;
      end else begin
        dx_next = dx_reg + 10'sd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dx_reg <= '0;
      dy_reg <= '0;
    end else begin
      dx_reg <= dx_next;
      dy_reg <= dy_next;
    end
  end

  // Coordinates are zero-extended before the add so an edge stamp goes
  // negative and is clipped rather than wrapping to the far side.
  assign px       = $signed({2'b00, cx}) + dx_next;
  assign py       = $signed({2'b00, cy}) + dy_next;
  assign in_range = (px >= 10'sd0) && (px < LIMIT) && (py >= 10'sd0) && (py < LIMIT);
  assign addr     = {py[CBITS-1:0], px[CBITS-1:0]};
  assign last     = (dx_reg == R) && (dy_reg == R);

endmodule

// File: rtl/brush_writer.sv
// Serializes brush stamps and canvas clears into one pixel write per clock
// on the pixel RAM write port.
module brush_writer
  import brush_writer_pkg::*;
#(
  parameter int RADIUS = 1,
  parameter int CBITS  = CANVAS_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  brush,
  input  logic                  clear,
  input  logic [COLOR_BITS-1:0] newColor,
  input  logic [7:0]            wx,
  input  logic [7:0]            wy,
  output logic                  ready,
  output logic                  wr_en,
  output logic [2*CBITS-1:0]    wr_addr,
  output logic [COLOR_BITS-1:0] wr_data
);

  brush_state_t          state_reg;
  logic                  ready_reg, wr_en_reg;
  logic [2*CBITS-1:0]    wr_addr_reg;
  logic [COLOR_BITS-1:0] wr_data_reg;

  logic [7:0]            cx_reg, cy_reg;
  logic [COLOR_BITS-1:0] color_reg;
  logic [7:0]            last_x_reg, last_y_reg;
  logic [COLOR_BITS-1:0] last_color_reg;
  logic                  last_valid_reg;

  logic                  duplicate, brush_go, scan_start, scan_step;
  logic [7:0]            base_x, base_y;
  logic [2*CBITS-1:0]    scan_addr;
  logic                  scan_in_range, scan_last;

  assign duplicate  = last_valid_reg && (wx == last_x_reg) && (wy == last_y_reg)
                      && (newColor == last_color_reg);
  assign brush_go   = brush && !clear && !duplicate;
  assign scan_start = (state_reg == ST_IDLE) && brush_go;
  assign scan_step  = (state_reg == ST_STAMP) && !scan_last;
  // The first stamp pixel is computed straight from the request inputs.
  assign base_x     = (state_reg == ST_IDLE) ? wx : cx_reg;
  assign base_y     = (state_reg == ST_IDLE) ? wy : cy_reg;

  stamp_scanner #(
    .RADIUS (RADIUS),
    .CBITS  (CBITS)
  ) u_scanner (
    .clk      (clk),
    .reset    (reset),
    .start    (scan_start),
    .step     (scan_step),
    .cx       (base_x),
    .cy       (base_y),
    .addr     (scan_addr),
    .in_range (scan_in_range),
    .last     (scan_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      ready_reg      <= 1'b1;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      cx_reg         <= '0;
      cy_reg         <= '0;
      color_reg      <= '0;
      last_x_reg     <= '0;
      last_y_reg     <= '0;
      last_color_reg <= '0;
      last_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (clear) begin
            state_reg   <= ST_CLEAR;
            ready_reg   <= 1'b0;
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= '0;
            wr_data_reg <= ERASE;
          end else if (brush_go) begin
            state_reg   <= ST_STAMP;
            ready_reg   <= 1'b0;
            cx_reg      <= wx;
            cy_reg      <= wy;
            color_reg   <= newColor;
            wr_en_reg   <= scan_in_range;
            wr_addr_reg <= scan_addr;
            wr_data_reg <= newColor;
          end
        end
        ST_STAMP: begin
          if (scan_last) begin
            state_reg      <= ST_IDLE;
            ready_reg      <= 1'b1;
            wr_en_reg      <= 1'b0;
            last_x_reg     <= cx_reg;
            last_y_reg     <= cy_reg;
            last_color_reg <= color_reg;
            last_valid_reg <= 1'b1;
          end else begin
            wr_en_reg   <= scan_in_range;
            wr_addr_reg <= scan_addr;
            wr_data_reg <= color_reg;
          end
        end
        ST_CLEAR: begin
          // wr_addr doubles as the clear address counter.
          if (wr_addr_reg == '1) begin
            state_reg      <= ST_IDLE;
            ready_reg      <= 1'b1;
            wr_en_reg      <= 1'b0;
            last_valid_reg <= 1'b0;
          end else begin
            wr_addr_reg <= wr_addr_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
          wr_en_reg <= 1'b0;
        end
      endcase
    end
  end

  assign ready   = ready_reg;
  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

endmodule
